cordic_rot_iter: RTL and testbench

//   Iterative CORDIC engine in rotation mode: rotates vector (xin,yin) by angle zin.
//   It is the inverse-direction partner of the combinational vectoring-mode CORDIC
//   (x,y -> angle): this block maps angle -> (cos,sin)-style vector. It sits behind the

---
 rtl/cordic_rot_iter_if.sv | 26 ++
 rtl/cordic_rot_iter.sv | 147 ++++++++++++++
 tb/tb_cordic_rot_iter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_rot_iter_if.sv
// Operand/result handshake bundle for the iterative rotation-mode CORDIC.
// Master drives operands and result acceptance; slave is the engine.
interface cordic_rot_iter_if #(
   parameter int XY_SZ = 16
);
   logic               in_valid;
   logic               in_ready;
   logic signed [XY_SZ:0] xin;
   logic signed [XY_SZ:0] yin;
   logic signed [XY_SZ:0] zin;
   logic               out_valid;
   logic               out_ready;
   logic signed [XY_SZ:0] xout;
   logic signed [XY_SZ:0] yout;
   logic signed [XY_SZ:0] zout;

   modport master (
      output in_valid, xin, yin, zin, out_ready,
      input  in_ready, out_valid, xout, yout, zout
   );

   modport slave (
      input  in_valid, xin, yin, zin, out_ready,
      output in_ready, out_valid, xout, yout, zout
   );
endinterface

// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock,
// angle -> vector, with quadrant pre-rotation and valid/ready on both sides.
module cordic_rot_iter #(
   parameter int XY_SZ = 16,
   parameter int ITER  = 16
) (
   input logic              clk,
   input logic              rst,
   cordic_rot_iter_if.slave bus
);

   typedef logic signed [XY_SZ:0] data_t;

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      DONE
   } state_t;

   localparam data_t    HALF_PI = data_t'(25736);
   localparam logic [3:0] LAST  = 4'(ITER - 1);

   function automatic data_t atan_lut(input logic [3:0] idx);
      data_t a;
      case (idx)
         4'd0:    a = data_t'(12868);
         4'd1:    a = data_t'(7596);
         4'd2:    a = data_t'(4014);
         4'd3:    a = data_t'(2037);
         4'd4:    a = data_t'(1023);
         4'd5:    a = data_t'(512);
         4'd6:    a = data_t'(256);
         4'd7:    a = data_t'(128);
         4'd8:    a = data_t'(64);
         4'd9:    a = data_t'(32);
         4'd10:   a = data_t'(16);
         4'd11:   a = data_t'(8);
         4'd12:   a = data_t'(4);
         4'd13:   a = data_t'(2);
         default: a = data_t'(1);
      endcase
      return a;
   endfunction

   state_t     state_q, state_d;
   data_t      x_q, y_q, z_q;
   data_t      x_d, y_d, z_d;
   data_t      xo_q, yo_q, zo_q;
   data_t      xo_d, yo_d, zo_d;
   logic [3:0] i_q, i_d;

   data_t x_sh, y_sh, x_step, y_step, z_step;
   logic  z_pos;

   // Single micro-rotation; d=+1 when the residual angle is non-negative.
   always_comb begin
      z_pos  = ~z_q[XY_SZ];
      x_sh   = x_q >>> i_q;
      y_sh   = y_q >>> i_q;
      x_step = z_pos ? x_q - y_sh : x_q + y_sh;
      y_step = z_pos ? y_q + x_sh : y_q - x_sh;
      z_step = z_pos ? z_q - atan_lut(i_q)
                     : z_q + atan_lut(i_q);
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      zo_d    = zo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               i_d     = 4'd0;
               state_d = ROT;
               // Fold |z| > pi/2 into the range the atan sum can cover.
               if (bus.zin > HALF_PI) begin
                  x_d = -bus.yin;
                  y_d = bus.xin;
                  z_d = bus.zin - HALF_PI;
               end else if (bus.zin < -HALF_PI) begin
                  x_d = bus.yin;
                  y_d = -bus.xin;
                  z_d = bus.zin + HALF_PI;
               end else begin
                  x_d = bus.xin;
                  y_d = bus.yin;
                  z_d = bus.zin;
               end
            end
         end
         ROT: begin
            x_d = x_step;
            y_d = y_step;
            z_d = z_step;
            if (i_q == LAST) begin
               xo_d    = x_step;
               yo_d    = y_step;
               zo_d    = z_step;
               state_d = DONE;
            end else begin
               i_d = i_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q  <= '0;
         y_q  <= '0;
         z_q  <= '0;
         i_q  <= '0;
         xo_q <= '0;
         yo_q <= '0;
         zo_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         z_q  <= z_d;
         i_q  <= i_d;
         xo_q <= xo_d;
         yo_q <= yo_d;
         zo_q <= zo_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.xout      = xo_q;
   assign bus.yout      = yo_q;
   assign bus.zout      = zo_q;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Scoreboard bench for cordic_rot_iter: directed angles, exact and
// tolerance checks, backpressure and mid-rotation reset.
module tb_cordic_rot_iter;

   localparam int ITER = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cordic_rot_iter_if #(.XY_SZ(16)) bus ();

   cordic_rot_iter #(.XY_SZ(16), .ITER(ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mx, my, mz;
      int ix, iy;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic chk_tol(input string name, input int act,
                          input int req, input int tol);
      int diff;
      diff = act - req;
      n_cmp++;
      if (diff > tol || diff < -tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d+-%0d", name, act, req, tol);
      end
   endtask

   // Reference: straightforward sweep of the rotation-mode recurrence.
   function automatic void model(input int xi, input int yi, input int zi,
                                 output int xo, output int yo, output int zo);
      logic signed [16:0] x, y, z, t, xs, ys;
      int at[16];
      at = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
             64, 32, 16, 8, 4, 2, 1, 1};
      x = 17'(xi);
      y = 17'(yi);
      z = 17'(zi);
      if (z > 17'sd25736) begin
         t = x; x = -y; y = t; z = z - 17'sd25736;
      end else if (z < -17'sd25736) begin
         t = x; x = y; y = -t; z = z + 17'sd25736;
      end
      for (int k = 0; k < ITER; k++) begin
         xs = x >>> k;
         ys = y >>> k;
         if (z >= 0) begin
            x = x - ys; y = y + xs; z = z - 17'(at[k]);
         end else begin
            x = x + ys; y = y - xs; z = z + 17'(at[k]);
         end
      end
      xo = int'(x);
      yo = int'(y);
      zo = int'(z);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got x=%0d y=%0d, want none",
                     bus.xout, bus.yout);
         end else begin
            e = sb.pop_front();
            chk("xout_exact", int'(bus.xout), e.mx);
            chk("yout_exact", int'(bus.yout), e.my);
            chk("zout_exact", int'(bus.zout), e.mz);
            chk_tol("xout_ideal", int'(bus.xout), e.ix, 8);
            chk_tol("yout_ideal", int'(bus.yout), e.iy, 8);
            chk_tol("zout_resid", int'(bus.zout), 0, 2);
         end
      end
   end

   task automatic send(input int x, input int y, input int z,
                       input int ix, input int iy);
      exp_t e;
      int   n = 0;
      while (!bus.in_ready && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.in_ready) chk("send_ready_timeout", 0, 1);
      @(negedge clk);
      bus.xin      = 17'(x);
      bus.yin      = 17'(y);
      bus.zin      = 17'(z);
      bus.in_valid = 1'b1;
      model(x, y, z, e.mx, e.my, e.mz);
      e.ix = ix;
      e.iy = iy;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.in_ready && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.in_ready) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int hx, hy, hz;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.xin       = '0;
      bus.yin       = '0;
      bus.zin       = '0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_xout", int'(bus.xout), 0);
      chk("rst_yout", int'(bus.yout), 0);
      chk("rst_zout", int'(bus.zout), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", int'(bus.in_ready), 1);

      // Angle 0: latency and hand-traced exact result (16383, 4, 0).
      send(9949, 0, 0, 16384, 0);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, ITER);
      chk("z0_hand_x", int'(bus.xout), 16383);
      chk("z0_hand_y", int'(bus.yout), 4);
      chk("z0_hand_z", int'(bus.zout), 0);
      wait_idle();

      send(9949, 0, 8579, 14189, 8192);
      wait_idle();
      send(9949, 0, 51472, -16384, 0);
      wait_idle();
      send(9949, 0, -25736, 0, -16384);
      wait_idle();
      send(0, 9949, 25736, -16384, 0);
      wait_idle();
      send(9949, 0, -51472, -16384, 0);
      wait_idle();

      // Backpressure in DONE with a stray operand offered.
      bus.out_ready = 1'b0;
      send(9949, 0, -8579, 14189, -8192);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      chk("bp_reached_done", int'(bus.out_valid), 1);
      hx = int'(bus.xout);
      hy = int'(bus.yout);
      hz = int'(bus.zout);
      @(negedge clk);
      bus.xin      = 17'(1234);
      bus.yin      = 17'(-777);
      bus.zin      = 17'(4000);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_hold_x", int'(bus.xout), hx);
         chk("bp_hold_y", int'(bus.yout), hy);
         chk("bp_hold_z", int'(bus.zout), hz);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_out_valid", int'(bus.out_valid), 1);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_idle", int'(bus.in_ready), 1);
      chk("bp_release_valid", int'(bus.out_valid), 0);
      repeat (ITER + 4) @(posedge clk);
      #1;
      chk("bp_no_queued_op", int'(bus.in_ready), 1);

      // Reset while the engine is at iteration 7.
      send(9949, 0, 8579, 14189, 8192);
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy", int'(bus.in_ready), 0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      chk("mid_rst_idle", int'(bus.in_ready), 1);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_xout", int'(bus.xout), 0);
      rst = 1'b0;
      send(9949, 0, -8579, 14189, -8192);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
